rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per owner while others wait (legal 1..255).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: req  input  8  request vector; bit i = requester i.
REQ-005 Port: gnt  output  8  registered one-hot grant; all-zero when no grant.
REQ-006 Port: gnt_idx  output  3  registered binary index of the owner; 0 when gnt_vld=0.
REQ-007 Port: gnt_vld  output  1  registered; 1 while a grant is held.

Function
REQ-008 The block SHALL have two states: IDLE (no owner) and GRANT (owner held); state SHALL be one-bit encoded.
REQ-009 The block SHALL hold ptr[2:0] (round-robin start) and hold_cnt[7:0].
REQ-010 Winner SHALL be the first set bit of the candidate vector searched in order ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-011 IDLE with req!=0 at an edge: SHALL enter GRANT with winner of req; gnt/gnt_idx/gnt_vld valid the next cycle (latency 1); hold_cnt<=1.
REQ-012 IDLE with req==0: SHALL remain IDLE, outputs zero.
REQ-013 GRANT, req[owner]=1 and hold_cnt<MAX_HOLD: SHALL keep owner; hold_cnt increments.
REQ-014 GRANT, req[owner]=0 (release): ptr<=owner+1 mod 8; if (req & ~onehot(owner))!=0, the winner of that vector searched from owner+1 SHALL be granted next cycle (no bubble), hold_cnt<=1; else go to IDLE with outputs zero next cycle.
REQ-015 GRANT, req[owner]=1, hold_cnt==MAX_HOLD, other requests pending: SHALL preempt exactly as REQ-014 (owner excluded, ptr<=owner+1); owner therefore holds exactly MAX_HOLD cycles.
REQ-016 GRANT, hold_cnt==MAX_HOLD, no other request: owner SHALL keep grant; hold_cnt saturates at MAX_HOLD.
REQ-017 Changes on non-owner req bits SHALL NOT affect the current grant before release or preemption.
REQ-018 gnt SHALL always equal onehot(gnt_idx) when gnt_vld=1 and 0 otherwise; never more than one bit set.
REQ-019 ptr wrap-around: owner 7 released SHALL give ptr=0.
REQ-020 ptr SHALL change only on release or preemption, never on entry from IDLE.

Reset
REQ-021 rst sampled high SHALL, at that edge, set state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, ptr=0, hold_cnt=0, regardless of state (mid-grant included).
REQ-022 rst SHALL take priority over all requests; first arbitration occurs at the first edge with rst low.

Structure
REQ-023 A shared package SHALL define the state enum (IDLE, GRANT), N_REQ=8, IDX_W=3, HOLD_W=8.
REQ-024 One combinational sub-module, rr_pick8 (inputs cand[7:0], start[2:0]; outputs idx[2:0], any), SHALL implement REQ-010 by rotating cand right by start, priority-picking the lowest set bit, and adding start mod 8.
REQ-025 All outputs SHALL come directly from flops; no combinational path from req to outputs.

Verification
REQ-026 After reset, req=8'b0000_0100 -> next cycle gnt=8'b0000_0100, gnt_idx=2, gnt_vld=1.
REQ-027 MAX_HOLD=4, req=8'hFF constant -> owners 0,1,2,...,7,0 each held exactly 4 cycles, no gap cycles, wrap 7->0.
REQ-028 Owner 3, req falls to 8'b0010_0010 -> next cycle gnt_idx=5 (ptr=4), gnt_vld=1, no idle cycle.
REQ-029 MAX_HOLD=4, req=8'h10 for 20 cycles -> gnt_idx=4 continuously; drop req -> gnt_vld=0 next cycle, ptr=5.
REQ-030 rst pulsed while owner=6 -> next cycle all outputs 0; then req=8'h81 -> gnt_idx=0 (ptr reset to 0).
REQ-031 req=0 for 10 cycles after reset -> gnt_vld=0, gnt=0 throughout; assertion on gnt one-hot/zero checked every cycle.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    // One-bit encoded arbiter state: no owner / owner held.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Binary requester index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_pick8.sv
// Round-robin picker: first set bit of cand searched from start upwards, wrapping.
// Rotates cand right by start, takes the lowest set bit, then adds start back.
module rr_pick8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first;
    logic [N_REQ:0]   below;   // below[i]: some rotated bit under position i is set

    assign below[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick
            // Index arithmetic wraps at IDX_W bits, giving the mod-8 rotation.
            assign rot[gi]      = cand[start + IDX_W'(gi)];
            assign first[gi]    = rot[gi] & ~below[gi];
            assign below[gi+1]  = below[gi] | rot[gi];
        end
    endgenerate

    // Encode the single set bit of first and undo the rotation.
    always_comb begin
        logic [IDX_W-1:0] offset;
        offset = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (first[i]) begin
                offset = IDX_W'(i);
            end
        end
        idx = start + offset;
        any = below[N_REQ];
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a per-owner hold limit.
// An owner keeps the grant while requesting, but after MAX_HOLD cycles it is
// preempted if anybody else is waiting. All outputs are registered.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [N_REQ-1:0]  gnt_reg;
    logic [IDX_W-1:0]  gnt_idx_reg;
    logic              gnt_vld_reg;

    logic [N_REQ-1:0]  pick_cand;
    logic [IDX_W-1:0]  pick_start;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic [IDX_W-1:0]  owner_next;

    // One picker serves both cases: from IDLE it searches all requests from
    // ptr; while granted it searches the other requesters from owner+1, which
    // is exactly the candidate set for a release or a preemption.
    assign owner_next = gnt_idx_reg + IDX_W'(1);
    assign pick_cand  = (state_reg == IDLE) ? req : (req & ~idx_to_onehot(gnt_idx_reg));
    assign pick_start = (state_reg == IDLE) ? ptr_reg : owner_next;
    assign owner_req  = req[gnt_idx_reg];

    rr_pick8 u_pick (
        .cand  (pick_cand),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            gnt_vld_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Entry from idle leaves ptr untouched.
                    if (pick_any) begin
                        state_reg    <= GRANT;
                        gnt_idx_reg  <= pick_idx;
                        gnt_reg      <= idx_to_onehot(pick_idx);
                        gnt_vld_reg  <= 1'b1;
                        hold_cnt_reg <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (owner_req && (hold_cnt_reg < MAX_HOLD_C)) begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end else if (owner_req && !pick_any) begin
                        // Limit reached but nobody waiting: keep owner, counter saturated.
                        hold_cnt_reg <= MAX_HOLD_C;
                    end else begin
                        // Release or preemption: advance past the owner.
                        ptr_reg <= owner_next;
                        if (pick_any) begin
                            gnt_idx_reg  <= pick_idx;
                            gnt_reg      <= idx_to_onehot(pick_idx);
                            hold_cnt_reg <= HOLD_W'(1);
                        end else begin
                            state_reg    <= IDLE;
                            gnt_idx_reg  <= '0;
                            gnt_reg      <= '0;
                            gnt_vld_reg  <= 1'b0;
                            hold_cnt_reg <= '0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_idx = gnt_idx_reg;
    assign gnt_vld = gnt_vld_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4): a behavioural reference
// pushes the expected outputs into a scoreboard when each request vector is
// driven; they are popped and compared one cycle later, after the clock edge.
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic       m_busy;
    logic [2:0] m_ptr;
    logic [2:0] m_owner;
    int         m_hold;

    // last observed outputs, for directed checks
    logic [7:0] obs_gnt;
    logic [2:0] obs_idx;
    logic       obs_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Linear wrap-around search: first set bit of c at s, s+1, ... (mod 8).
    function automatic logic [3:0] search(input logic [7:0] c, input logic [2:0] s);
        logic [2:0] i;
        for (int k = 0; k < 8; k++) begin
            i = s + k[2:0];
            if (c[i]) return {1'b1, i};
        end
        return 4'd0;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] q);
        logic [3:0] w;
        logic [7:0] others;
        if (r) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
        end else if (!m_busy) begin
            w = search(q, m_ptr);
            if (w[3]) begin
                m_busy = 1; m_owner = w[2:0]; m_hold = 1;
            end
        end else begin
            others = q & ~(8'd1 << m_owner);
            if (q[m_owner] && m_hold < MAXH) begin
                m_hold++;
            end else if (q[m_owner] && others == 8'd0) begin
                m_hold = MAXH;
            end else begin
                m_ptr = m_owner + 3'd1;
                w = search(others, m_ptr);
                if (w[3]) begin
                    m_owner = w[2:0]; m_hold = 1;
                end else begin
                    m_busy = 0; m_owner = 0; m_hold = 0;
                end
            end
        end
    endtask

    // One clock: drive, predict, wait for the edge, compare against the scoreboard.
    task automatic step(input logic r, input logic [7:0] q);
        exp_t e;
        rst = r;
        req = q;
        model_edge(r, q);
        e.vld = m_busy;
        e.idx = m_busy ? m_owner : 3'd0;
        e.gnt = m_busy ? (8'd1 << m_owner) : 8'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        obs_gnt = gnt; obs_idx = gnt_idx; obs_vld = gnt_vld;
        e = sb_q.pop_front();
        $display("cycle=%0d rst=%0d req=%02h gnt=%02h idx=%0d vld=%0d", cyc, r, q, gnt, gnt_idx, gnt_vld);
        check("gnt", {24'd0, gnt}, {24'd0, e.gnt});
        check("gnt_idx", {29'd0, gnt_idx}, {29'd0, e.idx});
        check("gnt_vld", {31'd0, gnt_vld}, {31'd0, e.vld});
        check("onehot", {31'd0, (gnt == (gnt_vld ? (8'd1 << gnt_idx) : 8'd0)) && $onehot0(gnt)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'd0;
        m_busy = 0; m_ptr = 0; m_owner = 0; m_hold = 0;

        // reset state, even with requests present
        step(1, 8'hFF);
        step(1, 8'h00);
        check("reset_vld", {31'd0, obs_vld}, 32'd0);
        check("reset_gnt", {24'd0, obs_gnt}, 32'd0);

        // single requester 2, latency one
        step(0, 8'h04);
        check("req2_gnt", {24'd0, obs_gnt}, 32'h04);
        check("req2_idx", {29'd0, obs_idx}, 32'd2);

        // all requesting: each owner exactly MAXH cycles, 0..7 then wrap to 0
        step(1, 8'h00);
        for (int k = 0; k < 8 * MAXH + 2; k++) begin
            step(0, 8'hFF);
            check("rr_seq", {29'd0, obs_idx}, (k / MAXH) % 8);
        end

        // owner 3 releases while 1 and 5 wait -> 5 with no idle cycle
        step(1, 8'h00);
        step(0, 8'h08);
        check("own3", {29'd0, obs_idx}, 32'd3);
        step(0, 8'h22);
        check("rel3_idx", {29'd0, obs_idx}, 32'd5);
        check("rel3_vld", {31'd0, obs_vld}, 32'd1);

        // lone requester 4 held past the limit, then released -> ptr=5
        step(1, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step(0, 8'h10);
            check("hold4", {29'd0, obs_idx}, 32'd4);
        end
        step(0, 8'h00);
        check("drop4_vld", {31'd0, obs_vld}, 32'd0);
        step(0, 8'h41);
        check("ptr5_pick", {29'd0, obs_idx}, 32'd6);

        // reset mid-grant clears ptr
        step(1, 8'h00);
        step(0, 8'h40);
        check("own6", {29'd0, obs_idx}, 32'd6);
        step(1, 8'h40);
        check("rst6_vld", {31'd0, obs_vld}, 32'd0);
        step(0, 8'h81);
        check("post_rst_idx", {29'd0, obs_idx}, 32'd0);

        // idle for ten cycles
        step(1, 8'h00);
        for (int k = 0; k < 10; k++) begin
            step(0, 8'h00);
            check("idle_vld", {31'd0, obs_vld}, 32'd0);
        end

        // random traffic, sparse and dense, against the reference model
        for (int k = 0; k < 120; k++) begin
            if (k % 3 == 0) step(0, 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
            else            step(0, 8'($urandom_range(0, 255)));
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
